// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared types and digit codes for the 7-segment display path.
//   - bin2bcd_state_t : sequencer states of the binary-to-BCD formatter
//   - SEG7_CODE_E     : digit code rendered as "E" (overflow marker)
//   - SEG7_CODE_BLANK : digit code rendered with all segments off
//   - SEG7_NUM_DIGITS : number of display digits
//   - BCD_NIBBLES     : BCD accumulator depth (ten-thousands..units)
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } bin2bcd_state_t;

  localparam logic [3:0] SEG7_CODE_E     = 4'd10;
  localparam logic [3:0] SEG7_CODE_BLANK = 4'd15;
  localparam int         SEG7_NUM_DIGITS = 4;
  // One nibble beyond the display width so values up to 99999 are exact.
  localparam int         BCD_NIBBLES     = SEG7_NUM_DIGITS + 1;

endpackage

// File: rtl/seg7_bin2bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble nibble correction: n >= 5 ? n + 3 : n.
//   Applied before each left shift so a digit that would reach >= 10 after
//   doubling carries correctly into the next nibble.
// Ports
//   i_nibble  in   4  BCD nibble before correction
//   o_nibble  out  4  corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/seg7_bin2bcd.sv
// -----------------------------------------------------------------------------
// seg7_bin2bcd
//   Sequential binary-to-BCD formatter feeding seg7_display. Converts one bit
//   per clock with shift-add-3, then formats four display digits with optional
//   leading-zero blanking and an overflow marker for values above 9999.
// Parameters
//   IN_WIDTH    width of bin_in (4..16)
//   BLANK_LZ    1 = blank leading zeros in digit_0..digit_2
//   OVF_CODE    code shown in digit_0 on overflow
//   BLANK_CODE  code rendered as all segments off
// Ports
//   clk      in   1         system clock
//   rst_n    in   1         asynchronous reset, active-low
//   start    in   1         conversion request, sampled only in IDLE
//   bin_in   in   IN_WIDTH  unsigned value, captured on the accepted start edge
//   busy     out  1         conversion in progress
//   done     out  1         one-cycle pulse, result updated on the same edge
//   valid    out  1         a result has been produced since reset
//   ovf      out  1         last result was > 9999
//   digit_0  out  4         thousands digit (leftmost)
//   digit_1  out  4         hundreds digit
//   digit_2  out  4         tens digit
//   digit_3  out  4         units digit (rightmost)
// -----------------------------------------------------------------------------
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int         IN_WIDTH   = 16,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [3:0] OVF_CODE   = SEG7_CODE_E,
  parameter logic [3:0] BLANK_CODE = SEG7_CODE_BLANK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic                ovf,
  output logic [3:0]          digit_0,
  output logic [3:0]          digit_1,
  output logic [3:0]          digit_2,
  output logic [3:0]          digit_3
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int BCD_W = 4 * BCD_NIBBLES;

  bin2bcd_state_t      r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_count;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic                w_ovf_det;
  logic [3:0]          w_dig0;
  logic [3:0]          w_dig1;
  logic [3:0]          w_dig2;
  logic [3:0]          w_dig3;

  // Per-nibble add-3 correction of the accumulator.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_NIBBLES; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .i_nibble (r_bcd[4*gi +: 4]),
        .o_nibble (w_bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Display formatting of the finished accumulator. Nibble 4 is the
  // ten-thousands place; nibbles 3..0 map to digit_0..digit_3.
  always_comb begin
    w_ovf_det = (r_bcd[19:16] != 4'd0);
    w_dig0    = r_bcd[15:12];
    w_dig1    = r_bcd[11:8];
    w_dig2    = r_bcd[7:4];
    w_dig3    = r_bcd[3:0];
    if (w_ovf_det) begin
      w_dig0 = OVF_CODE;
      w_dig1 = BLANK_CODE;
      w_dig2 = BLANK_CODE;
      w_dig3 = BLANK_CODE;
    end else if (BLANK_LZ) begin
      // Blank left to right only while every digit so far is zero, so inner
      // zeros (e.g. 1005) are kept and the units digit always shows.
      if (r_bcd[15:12] == 4'd0) begin
        w_dig0 = BLANK_CODE;
        if (r_bcd[11:8] == 4'd0) begin
          w_dig1 = BLANK_CODE;
          if (r_bcd[7:4] == 4'd0) begin
            w_dig2 = BLANK_CODE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_count <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
      digit_0 <= BLANK_CODE;
      digit_1 <= BLANK_CODE;
      digit_2 <= BLANK_CODE;
      digit_3 <= BLANK_CODE;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin_in;
            r_bcd   <= '0;
            r_count <= CNT_W'(IN_WIDTH);
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct, then shift the next binary MSB into the BCD LSB.
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_count        <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= FORMAT;
          end
        end
        FORMAT: begin
          digit_0 <= w_dig0;
          digit_1 <= w_dig1;
          digit_2 <= w_dig2;
          digit_3 <= w_dig3;
          ovf     <= w_ovf_det;
          busy    <= 1'b0;
          valid   <= 1'b1;
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// -----------------------------------------------------------------------------
// tb_seg7_bin2bcd
//   Drives a default build and a BLANK_LZ=0 build from the same stimulus and
//   compares both against a decimal-arithmetic reference every cycle, plus
//   literal expectations for hand-picked values.
// -----------------------------------------------------------------------------
module tb_seg7_bin2bcd;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] bin_in = '0;

  logic       busy, done, valid, ovf;
  logic [3:0] d0, d1, d2, d3;
  logic       nb_busy, nb_done, nb_valid, nb_ovf;
  logic [3:0] nb_d0, nb_d1, nb_d2, nb_d3;

  always #5 clk = ~clk;

  seg7_bin2bcd #(.IN_WIDTH(W), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .valid(valid), .ovf(ovf),
    .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3)
  );

  seg7_bin2bcd #(.IN_WIDTH(W), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(nb_busy), .done(nb_done), .valid(nb_valid), .ovf(nb_ovf),
    .digit_0(nb_d0), .digit_1(nb_d1), .digit_2(nb_d2), .digit_3(nb_d3)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
  endtask

  // Reference formatting: {ovf, digit_0, digit_1, digit_2, digit_3}.
  function automatic logic [16:0] fmt(input int v, input bit blank);
    logic [3:0] d[4];
    if (v > 9999) return {1'b1, 4'd10, 4'd15, 4'd15, 4'd15};
    d[0] = 4'(v / 1000);
    d[1] = 4'((v / 100) % 10);
    d[2] = 4'((v / 10) % 10);
    d[3] = 4'(v % 10);
    if (blank) begin
      for (int i = 0; i < 3; i++) begin
        if (d[i] != 4'd0) break;
        d[i] = 4'd15;
      end
    end
    return {1'b0, d[0], d[1], d[2], d[3]};
  endfunction

  function automatic logic [16:0] lit(input bit o, input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
    return {o, a, b, c, d};
  endfunction

  // Behavioural model: a request is accepted when no conversion is pending;
  // the formatted result appears LAT edges after acceptance.
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_valid = 1'b0;
  logic [16:0] m_res    = {1'b0, 4'd15, 4'd15, 4'd15, 4'd15};
  logic [16:0] m_res_nb = {1'b0, 4'd15, 4'd15, 4'd15, 4'd15};
  int          m_cnt   = 0;
  int          m_val   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_valid  <= 1'b0;
      m_res    <= {1'b0, 4'd15, 4'd15, 4'd15, 4'd15};
      m_res_nb <= {1'b0, 4'd15, 4'd15, 4'd15, 4'd15};
      m_cnt    <= 0;
      m_val    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_res    <= fmt(m_val, 1'b1);
          m_res_nb <= fmt(m_val, 1'b0);
          m_done   <= 1'b1;
          m_busy   <= 1'b0;
          m_valid  <= 1'b1;
        end
      end else if (start) begin
        m_val  <= int'(bin_in);
        m_cnt  <= LAT;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_done_overlap", 32'(busy & done), 32'd0);
      chk("cycle_out", 32'({busy, done, valid, ovf, d0, d1, d2, d3}),
          32'({m_busy, m_done, m_valid, m_res}));
      chk("cycle_out_nb", 32'({nb_busy, nb_done, nb_valid, nb_ovf, nb_d0, nb_d1, nb_d2, nb_d3}),
          32'({m_busy, m_done, m_valid, m_res_nb}));
    end
  end

  // Called at posedge+1: request for one cycle; returns at accept edge + 1.
  task automatic pulse(input logic [W-1:0] v);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input int v, input logic [16:0] e, input logic [16:0] e_nb,
                              input int cyc, input int exp_cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_digits"}, 32'({ovf, d0, d1, d2, d3}), 32'(e));
    chk({tag, "_digits_nb"}, 32'({nb_ovf, nb_d0, nb_d1, nb_d2, nb_d3}), 32'(e_nb));
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    $display("conv %s bin=%0d -> ovf=%0d digits=%0d,%0d,%0d,%0d nb=%0d,%0d,%0d,%0d cycles=%0d",
             tag, v, ovf, d0, d1, d2, d3, nb_d0, nb_d1, nb_d2, nb_d3, cyc);
  endtask

  task automatic convert(input string tag, input logic [W-1:0] v, input logic [16:0] e, input logic [16:0] e_nb);
    int c;
    pulse(v);
    wait_done(c);
    check_result(tag, int'(v), e, e_nb, c, LAT);
  endtask

  initial begin
    int c;
    int nd;
    logic [W-1:0] v;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("reset_ctrl", 32'({busy, done, valid, ovf}), 32'd0);
    chk("reset_digits", 32'({d0, d1, d2, d3}), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    convert("1234", 16'd1234, lit(0, 1, 2, 3, 4), lit(0, 1, 2, 3, 4));
    convert("0", 16'd0, lit(0, 15, 15, 15, 0), lit(0, 0, 0, 0, 0));
    convert("42", 16'd42, lit(0, 15, 15, 4, 2), lit(0, 0, 0, 4, 2));
    convert("1005", 16'd1005, lit(0, 1, 0, 0, 5), lit(0, 1, 0, 0, 5));
    convert("9999", 16'd9999, lit(0, 9, 9, 9, 9), lit(0, 9, 9, 9, 9));
    convert("10000", 16'd10000, lit(1, 10, 15, 15, 15), lit(1, 10, 15, 15, 15));
    convert("65535", 16'd65535, lit(1, 10, 15, 15, 15), lit(1, 10, 15, 15, 15));

    // A request while busy is ignored; later bin_in changes do not matter.
    pulse(16'd4321);
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = 16'd7;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 16'hFFFF;
    wait_done(c);
    check_result("ignore", 4321, lit(0, 4, 3, 2, 1), lit(0, 4, 3, 2, 1), c, LAT - 5);

    // start held during the done cycle is accepted immediately.
    start  = 1'b1;
    bin_in = 16'd555;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("held_accept_busy", 32'({busy, done}), 32'b10);
    wait_done(c);
    check_result("held", 555, lit(0, 15, 5, 5, 5), lit(0, 0, 5, 5, 5), c, LAT);

    // Asynchronous reset in the middle of a conversion.
    pulse(16'd3210);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 32'({busy, done, valid, ovf}), 32'd0);
    chk("abort_digits", 32'({d0, d1, d2, d3}), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    convert("after_abort", 16'd8765, lit(0, 8, 7, 6, 5), lit(0, 8, 7, 6, 5));

    // Random conversions with idle gaps.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) v = 16'($urandom_range(0, 10050));
      else v = 16'($urandom_range(0, 65535));
      pulse(v);
      wait_done(c);
      check_result("rand", int'(v), fmt(int'(v), 1'b1), fmt(int'(v), 1'b0), c, LAT);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Free-running random start/bin_in, including requests while busy and
    // on the done cycle; the per-cycle compare tracks everything.
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      bin_in = 16'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
